mhp_tx_framer: RTL and testbench

Transmit-side MHP frame builder that sits directly upstream of the MHP engine's Ethernet write port.
- Latches header fields on a start strobe.
- Streams header, payload (pulled from a user byte stream), optional alignment pad and a computed 16-bit checksum as a valid/ready byte stream into the Ethernet TX byte FIFO.
- Replaces the hard-coded header/zero-checksum transmit path with real framing.

---
 rtl/mhp_pkg.sv | 21 ++
 rtl/mhp_tx_framer_if.sv | 19 +
 rtl/mhp_csum.sv | 36 +++
 rtl/mhp_tx_framer.sv | 182 ++++++++++++++++++
 tb/tb_mhp_tx_framer.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/mhp_pkg.sv
// Shared MHP definitions: header length, framer state encoding and byte-lane helpers.
// Used by both the transmit framer and the receive side.
package mhp_pkg;

  localparam int unsigned HDR_LEN          = 7;
  localparam logic [15:0] MAX_SIZE_DEFAULT = 16'd1024;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StPayload,
    StPad,
    StCsumHi,
    StCsumLo
  } mhp_state_e;

  function automatic logic [7:0] byte_sel(input logic [15:0] word, input logic hi);
    return hi ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/mhp_tx_framer_if.sv
// Byte-stream bundle for the framer: payload input stream and Ethernet TX output stream.
interface mhp_tx_framer_if;
  logic [7:0] i_pdata;
  logic       i_pvalid;
  logic       o_pready;
  logic [7:0] o_wdata;
  logic       o_wvalid;
  logic       i_wready;

  modport master (
    output i_pdata, i_pvalid, i_wready,
    input  o_pready, o_wdata, o_wvalid
  );

  modport slave (
    input  i_pdata, i_pvalid, i_wready,
    output o_pready, o_wdata, o_wvalid
  );
endinterface

// File: rtl/mhp_csum.sv
// Two-lane XOR checksum: even-index bytes fold into the high lane, odd-index into the low lane.
module mhp_csum (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [7:0]  i_byte,
  input  logic        i_odd,
  output logic [15:0] o_csum
);

  logic [7:0] hi_q, lo_q;
  logic [7:0] hi_base, lo_base;

  // Clear and accumulate may coincide so the first byte of a frame is not lost.
  always_comb begin
    hi_base = i_clr ? 8'h00 : hi_q;
    lo_base = i_clr ? 8'h00 : lo_q;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      hi_q <= 8'h00;
      lo_q <= 8'h00;
    end else if (i_en) begin
      hi_q <= i_odd ? hi_base : (hi_base ^ i_byte);
      lo_q <= i_odd ? (lo_base ^ i_byte) : lo_base;
    end else if (i_clr) begin
      hi_q <= 8'h00;
      lo_q <= 8'h00;
    end
  end

  assign o_csum = {hi_q, lo_q};

endmodule

// File: rtl/mhp_tx_framer.sv
// MHP transmit framer: header, payload, optional pad and XOR checksum onto a byte stream.
module mhp_tx_framer
  import mhp_pkg::*;
#(
  parameter logic [15:0] MAX_SIZE = MAX_SIZE_DEFAULT
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic [15:0]            i_dst,
  input  logic [15:0]            i_src,
  input  logic [15:0]            i_size,
  input  logic [7:0]             i_dtype,
  mhp_tx_framer_if.slave         bus,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err,
  output logic [15:0]            o_csum
);

  mhp_state_e  state_q;
  logic [15:0] dst_q, src_q, size_q, cnt_q, csum_q;
  logic [7:0]  dtype_q, wdata_q;
  logic [2:0]  hdr_idx_q;
  logic        wvalid_q, odd_q, last_q, busy_q, done_q, err_q;

  logic        ld, start_ok;
  logic        acc_clr, acc_en, acc_odd;
  logic [7:0]  acc_byte, hdr_byte;
  logic [15:0] csum;

  assign ld       = !wvalid_q || bus.i_wready;
  assign start_ok = (state_q == StIdle) && i_start && (i_size <= MAX_SIZE);

  always_comb begin
    unique case (hdr_idx_q)
      3'd1:    hdr_byte = byte_sel(dst_q, 1'b0);
      3'd2:    hdr_byte = byte_sel(src_q, 1'b1);
      3'd3:    hdr_byte = byte_sel(src_q, 1'b0);
      3'd4:    hdr_byte = byte_sel(size_q, 1'b1);
      3'd5:    hdr_byte = byte_sel(size_q, 1'b0);
      3'd6:    hdr_byte = dtype_q;
      default: hdr_byte = byte_sel(dst_q, 1'b1);
    endcase
  end

  // Selects the body byte loaded into the output register this cycle, if any.
  always_comb begin
    acc_clr  = 1'b0;
    acc_en   = 1'b0;
    acc_odd  = odd_q;
    acc_byte = 8'h00;
    unique case (state_q)
      StIdle: begin
        acc_clr  = start_ok;
        acc_en   = start_ok;
        acc_odd  = 1'b0;
        acc_byte = byte_sel(i_dst, 1'b1);
      end
      StHdr: begin
        acc_en   = ld;
        acc_byte = hdr_byte;
      end
      StPayload: begin
        acc_en   = ld && bus.i_pvalid;
        acc_byte = bus.i_pdata;
      end
      StPad:   acc_en = ld;
      default: acc_en = 1'b0;
    endcase
  end

  mhp_csum u_csum (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (acc_clr),
    .i_en   (acc_en),
    .i_byte (acc_byte),
    .i_odd  (acc_odd),
    .o_csum (csum)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= StIdle;
      dst_q     <= '0;
      src_q     <= '0;
      size_q    <= '0;
      dtype_q   <= '0;
      cnt_q     <= '0;
      hdr_idx_q <= '0;
      wdata_q   <= '0;
      wvalid_q  <= 1'b0;
      odd_q     <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      csum_q    <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (acc_en) begin
        wdata_q  <= acc_byte;
        wvalid_q <= 1'b1;
        odd_q    <= (state_q == StIdle) ? 1'b1 : !odd_q;
      end else if (ld) begin
        wvalid_q <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (i_start && !start_ok) begin
            err_q <= 1'b1;
          end else if (start_ok) begin
            dst_q     <= i_dst;
            src_q     <= i_src;
            size_q    <= i_size;
            dtype_q   <= i_dtype;
            cnt_q     <= '0;
            hdr_idx_q <= 3'd1;
            busy_q    <= 1'b1;
            state_q   <= StHdr;
          end
        end
        StHdr: begin
          if (ld) begin
            hdr_idx_q <= hdr_idx_q + 3'd1;
            if (hdr_idx_q == 3'(HDR_LEN - 1)) begin
              state_q <= (size_q == 16'd0) ? StPad : StPayload;
            end
          end
        end
        StPayload: begin
          if (ld && bus.i_pvalid) begin
            cnt_q <= cnt_q + 16'd1;
            if (cnt_q + 16'd1 == size_q) begin
              // Odd payload already makes the body even-length.
              state_q <= size_q[0] ? StCsumHi : StPad;
            end
          end
        end
        StPad: begin
          if (ld) state_q <= StCsumHi;
        end
        StCsumHi: begin
          if (ld) begin
            wdata_q  <= csum[15:8];
            wvalid_q <= 1'b1;
            last_q   <= 1'b0;
            state_q  <= StCsumLo;
          end
        end
        StCsumLo: begin
          if (!last_q) begin
            if (ld) begin
              wdata_q  <= csum[7:0];
              wvalid_q <= 1'b1;
              last_q   <= 1'b1;
            end
          end else if (bus.i_wready) begin
            wvalid_q <= 1'b0;
            last_q   <= 1'b0;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            csum_q   <= csum;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.o_pready = (state_q == StPayload) && ld;
  assign bus.o_wdata  = wdata_q;
  assign bus.o_wvalid = wvalid_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_err        = err_q;
  assign o_csum       = csum_q;

endmodule

// File: tb/tb_mhp_tx_framer.sv
// Directed self-checking bench for mhp_tx_framer with hand-computed frame checksums.
module tb_mhp_tx_framer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] dst = '0, src = '0, size = '0;
  logic [7:0]  dtype = '0;
  logic        busy, done, err;
  logic [15:0] csum;
  logic [7:0]  pay [0:1099];
  int          errors = 0;
  int          checks = 0;

  mhp_tx_framer_if bus ();

  mhp_tx_framer #(.MAX_SIZE(16'd1024)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_dst   (dst),
    .i_src   (src),
    .i_size  (size),
    .i_dtype (dtype),
    .bus     (bus.slave),
    .o_busy  (busy),
    .o_done  (done),
    .o_err   (err),
    .o_csum  (csum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_frame(input logic [15:0] f_dst, input logic [15:0] f_src,
                           input logic [15:0] f_size, input logic [7:0] f_dtype,
                           input bit stall, input int gap, input bit no_wait,
                           input logic [15:0] exp_csum, input string tag);
    logic [7:0] exp_q[$];
    logic [7:0] got[$];
    int pidx = 0, gapcnt = 0, stall_bad = 0, pr_bad = 0, nbad = 0;
    bit prev_stall = 1'b0, seen_done = 1'b0;
    logic [7:0] prev_data = 8'h00;
    exp_q = {f_dst[15:8], f_dst[7:0], f_src[15:8], f_src[7:0],
             f_size[15:8], f_size[7:0], f_dtype};
    for (int i = 0; i < int'(f_size); i++) exp_q.push_back(pay[i]);
    if (!f_size[0]) exp_q.push_back(8'h00);
    exp_q.push_back(exp_csum[15:8]);
    exp_q.push_back(exp_csum[7:0]);
    if (!no_wait) @(negedge clk);
    start = 1'b1; dst = f_dst; src = f_src; size = f_size; dtype = f_dtype;
    bus.i_pvalid = 1'b0; bus.i_wready = 1'b1;
    for (int cyc = 0; cyc < 4000 && !seen_done; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      bus.i_wready = stall ? cyc[0] : 1'b1;
      bus.i_pvalid = (pidx < int'(f_size)) && (gapcnt == 0);
      bus.i_pdata  = bus.i_pvalid ? pay[pidx] : 8'h00;
      #1;
      if (cyc == 0) chk({tag, "_first_byte"}, {23'd0, bus.o_wvalid, bus.o_wdata},
                        {23'd0, 1'b1, f_dst[15:8]});
      if (prev_stall && (bus.o_wdata !== prev_data || bus.o_wvalid !== 1'b1)) stall_bad++;
      prev_stall = bus.o_wvalid && !bus.i_wready;
      prev_data  = bus.o_wdata;
      if (bus.o_pready && (got.size() < 6 || pidx >= int'(f_size))) pr_bad++;
      if (bus.o_wvalid && bus.i_wready) got.push_back(bus.o_wdata);
      if (bus.i_pvalid && bus.o_pready) begin
        pidx++;
        gapcnt = gap;
      end else if (gapcnt > 0) begin
        gapcnt--;
      end
      if (done) begin
        seen_done = 1'b1;
        chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        chk({tag, "_csum"}, {16'd0, csum}, {16'd0, exp_csum});
      end
    end
    bus.i_pvalid = 1'b0;
    chk({tag, "_done_seen"}, {31'd0, seen_done}, 32'd1);
    chk({tag, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      if (got[i] !== exp_q[i]) nbad++;
    chk({tag, "_bytes_wrong"}, nbad, 0);
    chk({tag, "_stall_hold"}, stall_bad, 0);
    chk({tag, "_pready_window"}, pr_bad, 0);
  endtask

  initial begin
    bus.i_pdata = 8'h00; bus.i_pvalid = 1'b0; bus.i_wready = 1'b1;
    for (int i = 0; i < 1100; i++) pay[i] = 8'h00;

    // Reset state
    #13;
    chk("rst_wvalid", {31'd0, bus.o_wvalid}, 32'd0);
    chk("rst_pready", {31'd0, bus.o_pready}, 32'd0);
    chk("rst_busy_done_err", {29'd0, busy, done, err}, 32'd0);
    chk("rst_wdata_csum", {8'd0, bus.o_wdata, csum}, 32'd0);
    @(negedge clk); rst = 1'b1;

    // size 0: FF FF 00 00 00 00 83 00 7C FF
    run_frame(16'hFFFF, 16'h0000, 16'd0, 8'h83, 1'b0, 0, 1'b0, 16'h7CFF, "f_size0");
    // Back-to-back, size 1: FF FF 00 00 00 01 83 55 7C AB
    pay[0] = 8'h55;
    run_frame(16'hFFFF, 16'h0000, 16'd1, 8'h83, 1'b0, 0, 1'b1, 16'h7CAB, "f_size1_b2b");
    @(negedge clk); #1;
    chk("done_single_pulse", {31'd0, done}, 32'd0);

    // size 0 with output backpressure toggling
    run_frame(16'hFFFF, 16'h0000, 16'd0, 8'h83, 1'b1, 0, 1'b0, 16'h7CFF, "f_stall");

    // size 4, gapped payload: 12 34 AB CD 00 04 05 01 02 03 04 00 BA FF
    pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03; pay[3] = 8'h04;
    run_frame(16'h1234, 16'hABCD, 16'd4, 8'h05, 1'b0, 3, 1'b0, 16'hBAFF, "f_gapped");

    // Oversize request is rejected
    @(negedge clk);
    start = 1'b1; size = 16'd1025; dst = 16'h1111;
    @(negedge clk); start = 1'b0; #1;
    chk("oversize_err", {31'd0, err}, 32'd1);
    chk("oversize_quiet", {30'd0, bus.o_wvalid, busy}, 32'd0);
    @(negedge clk); #1;
    chk("oversize_err_pulse", {29'd0, err, bus.o_wvalid, busy}, 32'd0);

    // MAX_SIZE payload of i[7:0]: payload XOR cancels per lane, checksum 78FF
    for (int i = 0; i < 1024; i++) pay[i] = 8'(i);
    run_frame(16'hFFFF, 16'h0000, 16'd1024, 8'h83, 1'b0, 0, 1'b0, 16'h78FF, "f_max");

    // Asynchronous reset while payload byte 2 is on offer
    pay[0] = 8'hA1; pay[1] = 8'hA2; pay[2] = 8'hA3; pay[3] = 8'hA4;
    @(negedge clk);
    start = 1'b1; dst = 16'hFFFF; src = 16'h0000; size = 16'd4; dtype = 8'h83;
    bus.i_wready = 1'b1; bus.i_pvalid = 1'b1; bus.i_pdata = 8'hA1;
    @(negedge clk); start = 1'b0;
    repeat (8) @(negedge clk);
    #2;
    chk("mid_pready", {31'd0, bus.o_pready}, 32'd1);
    rst = 1'b0;
    #1;
    chk("async_rst_drop", {29'd0, bus.o_wvalid, busy, bus.o_pready}, 32'd0);
    chk("async_rst_csum", {16'd0, csum}, 32'd0);
    @(negedge clk); rst = 1'b1; bus.i_pvalid = 1'b0;
    @(negedge clk); #1;
    chk("post_rst_idle", {30'd0, bus.o_wvalid, busy}, 32'd0);
    pay[0] = 8'h55;
    run_frame(16'hFFFF, 16'h0000, 16'd1, 8'h83, 1'b0, 0, 1'b0, 16'h7CAB, "f_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
